// File: rtl/stream_minmax_pkg.sv
// Shared types for stream_minmax: FSM state encoding and the result beat layout
// at the default sample/counter widths used by the report path.
package stream_minmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  localparam int RESULT_WIDTH = 8;
  localparam int RESULT_CNT_W = 8;

  typedef struct packed {
    logic [RESULT_WIDTH-1:0] max;
    logic [RESULT_WIDTH-1:0] min;
    logic [RESULT_CNT_W-1:0] count;
    logic                    ovf;
    logic                    all_eq;
  } result_t;

endpackage

// File: rtl/stream_minmax_if.sv
// Sample stream in / result beat out for stream_minmax.
// STREAM_MINMAX_IDX_EN adds the first-occurrence index outputs.
interface stream_minmax_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_all_eq;

`ifdef STREAM_MINMAX_IDX_EN
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_min_idx;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count, out_ovf, out_all_eq,
    input  out_max_idx, out_min_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count, out_ovf, out_all_eq,
    output out_max_idx, out_min_idx
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count, out_ovf, out_all_eq
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count, out_ovf, out_all_eq
  );
`endif

endinterface

// File: rtl/comparator.sv
// Team combinational unsigned magnitude comparator.
module comparator #(
  parameter int size = 8
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            a_gt_b,
  output logic            a_lt_b,
  output logic            a_eq_b
);

  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);

endmodule

// File: rtl/stream_minmax.sv
// Running max/min over a framed sample stream, one result beat per frame.
// Optional first-occurrence indices under STREAM_MINMAX_IDX_EN.
module stream_minmax
  import stream_minmax_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_minmax_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Same layout as result_t, sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             all_eq;
  } frame_t;

  state_e state_q, state_d;
  frame_t res_q, res_d;

`ifdef STREAM_MINMAX_IDX_EN
  logic [CNT_W-1:0] maxIdx_q, maxIdx_d;
  logic [CNT_W-1:0] minIdx_q, minIdx_d;
`endif

  logic inReady;
  logic accept;
  logic maxGt, maxLt, maxEq;
  logic minGt, minLt, minEq;
  logic unusedCmpFlags;

  comparator #(.size(WIDTH)) u_cmpMax (
    .a      (bus.in_data),
    .b      (res_q.max),
    .a_gt_b (maxGt),
    .a_lt_b (maxLt),
    .a_eq_b (maxEq)
  );

  comparator #(.size(WIDTH)) u_cmpMin (
    .a      (bus.in_data),
    .b      (res_q.min),
    .a_gt_b (minGt),
    .a_lt_b (minLt),
    .a_eq_b (minEq)
  );

  assign unusedCmpFlags = ^{maxLt, minGt, minEq};

  assign inReady = (state_q != HOLD);
  assign accept  = bus.in_valid && inReady;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
`ifdef STREAM_MINMAX_IDX_EN
    maxIdx_d = maxIdx_q;
    minIdx_d = minIdx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          res_d.max    = bus.in_data;
          res_d.min    = bus.in_data;
          res_d.count  = CNT_W'(1);
          res_d.ovf    = 1'b0;
          res_d.all_eq = 1'b1;
`ifdef STREAM_MINMAX_IDX_EN
          maxIdx_d = '0;
          minIdx_d = '0;
`endif
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // count_q is the zero-based position of this sample and already saturates.
          if (maxGt) begin
            res_d.max = bus.in_data;
`ifdef STREAM_MINMAX_IDX_EN
            maxIdx_d = res_q.count;
`endif
          end
          if (minLt) begin
            res_d.min = bus.in_data;
`ifdef STREAM_MINMAX_IDX_EN
            minIdx_d = res_q.count;
`endif
          end
          if (!maxEq) begin
            res_d.all_eq = 1'b0;
          end
          if (res_q.count == CNT_MAX) begin
            res_d.ovf = 1'b1;
          end else begin
            res_d.count = res_q.count + CNT_W'(1);
          end
          if (bus.in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
`ifdef STREAM_MINMAX_IDX_EN
      maxIdx_q <= '0;
      minIdx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
`ifdef STREAM_MINMAX_IDX_EN
      maxIdx_q <= maxIdx_d;
      minIdx_q <= minIdx_d;
`endif
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_max    = res_q.max;
  assign bus.out_min    = res_q.min;
  assign bus.out_count  = res_q.count;
  assign bus.out_ovf    = res_q.ovf;
  assign bus.out_all_eq = res_q.all_eq;
`ifdef STREAM_MINMAX_IDX_EN
  assign bus.out_max_idx = maxIdx_q;
  assign bus.out_min_idx = minIdx_q;
`endif

endmodule

// File: tb/tb_stream_minmax.sv
// Scoreboard bench for stream_minmax: an 8-bit counter instance and a 3-bit counter
// instance for saturation. Index checks are active when STREAM_MINMAX_IDX_EN is defined.
module tb_stream_minmax;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [7:0] cnt;
    logic       ovf;
    logic       eq;
    logic [7:0] mxIdx;
    logic [7:0] mnIdx;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  expect_t expA[$];
  expect_t expB[$];
  expect_t monA;
  expect_t monB;

  stream_minmax_if #(.WIDTH(8), .CNT_W(8)) busA ();
  stream_minmax_if #(.WIDTH(8), .CNT_W(3)) busB ();

  stream_minmax #(.WIDTH(8), .CNT_W(8)) dutA (.clk(clk), .rst(rst), .bus(busA));
  stream_minmax #(.WIDTH(8), .CNT_W(3)) dutB (.clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Drive one sample on bus A (sel=0) or bus B (sel=1); called and returns at posedge+1.
  task automatic applyStimulus(input bit sel, input logic [7:0] d, input bit last);
    int waitCycles = 0;
    if (sel) begin
      busB.in_valid = 1'b1; busB.in_data = d; busB.in_last = last;
    end else begin
      busA.in_valid = 1'b1; busA.in_data = d; busA.in_last = last;
    end
    while (!(sel ? busB.in_ready : busA.in_ready) && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (waitCycles >= 50) reportFail("inReadyTimeout");
    @(posedge clk); #1;
    if (sel) busB.in_valid = 1'b0;
    else     busA.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && busA.out_valid && busA.out_ready) begin
      if (expA.size() == 0) begin
        reportFail("unexpectedResultA");
      end else begin
        monA = expA.pop_front();
        checkOutput("maxA",   32'(busA.out_max),    32'(monA.mx));
        checkOutput("minA",   32'(busA.out_min),    32'(monA.mn));
        checkOutput("countA", 32'(busA.out_count),  32'(monA.cnt));
        checkOutput("ovfA",   32'(busA.out_ovf),    32'(monA.ovf));
        checkOutput("allEqA", 32'(busA.out_all_eq), 32'(monA.eq));
`ifdef STREAM_MINMAX_IDX_EN
        checkOutput("maxIdxA", 32'(busA.out_max_idx), 32'(monA.mxIdx));
        checkOutput("minIdxA", 32'(busA.out_min_idx), 32'(monA.mnIdx));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && busB.out_valid && busB.out_ready) begin
      if (expB.size() == 0) begin
        reportFail("unexpectedResultB");
      end else begin
        monB = expB.pop_front();
        checkOutput("maxB",   32'(busB.out_max),    32'(monB.mx));
        checkOutput("minB",   32'(busB.out_min),    32'(monB.mn));
        checkOutput("countB", 32'(busB.out_count),  32'(monB.cnt));
        checkOutput("ovfB",   32'(busB.out_ovf),    32'(monB.ovf));
        checkOutput("allEqB", 32'(busB.out_all_eq), 32'(monB.eq));
`ifdef STREAM_MINMAX_IDX_EN
        checkOutput("maxIdxB", 32'(busB.out_max_idx), 32'(monB.mxIdx));
        checkOutput("minIdxB", 32'(busB.out_min_idx), 32'(monB.mnIdx));
`endif
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rstInReady",  32'(busA.in_ready),   32'd1);
    checkOutput("rstOutValid", 32'(busA.out_valid),  32'd0);
    checkOutput("rstMax",      32'(busA.out_max),    32'd0);
    checkOutput("rstMin",      32'(busA.out_min),    32'd0);
    checkOutput("rstCount",    32'(busA.out_count),  32'd0);
    checkOutput("rstOvf",      32'(busA.out_ovf),    32'd0);
    checkOutput("rstAllEq",    32'(busA.out_all_eq), 32'd0);
`ifdef STREAM_MINMAX_IDX_EN
    checkOutput("rstMaxIdx",   32'(busA.out_max_idx), 32'd0);
    checkOutput("rstMinIdx",   32'(busA.out_min_idx), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] longFrame [10];
    int guard;
    busA.in_valid = 1'b0; busA.in_data = '0; busA.in_last = 1'b0; busA.out_ready = 1'b1;
    busB.in_valid = 1'b0; busB.in_data = '0; busB.in_last = 1'b0; busB.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    checkOutput("rstInReadyB",  32'(busB.in_ready),  32'd1);
    checkOutput("rstOutValidB", 32'(busB.out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] frame 5,9,3,9,7");
    expA.push_back('{mx: 8'd9, mn: 8'd3, cnt: 8'd5, ovf: 1'b0, eq: 1'b0, mxIdx: 8'd1, mnIdx: 8'd2});
    applyStimulus(0, 8'd5, 0);
    applyStimulus(0, 8'd9, 0);
    applyStimulus(0, 8'd3, 0);
    applyStimulus(0, 8'd9, 0);
    applyStimulus(0, 8'd7, 1);

    $display("[TB] single sample 0x42");
    expA.push_back('{mx: 8'h42, mn: 8'h42, cnt: 8'd1, ovf: 1'b0, eq: 1'b1, mxIdx: 8'd0, mnIdx: 8'd0});
    applyStimulus(0, 8'h42, 1);
    checkOutput("singleValidLatency", 32'(busA.out_valid), 32'd1);
    checkOutput("singleReadyInHold",  32'(busA.in_ready),  32'd0);
    @(posedge clk); #1;
    checkOutput("singleValidDrop",    32'(busA.out_valid), 32'd0);
    checkOutput("singleReadyReturn",  32'(busA.in_ready),  32'd1);

    $display("[TB] frame 7,7,7 and 0xFF,0x00");
    expA.push_back('{mx: 8'd7, mn: 8'd7, cnt: 8'd3, ovf: 1'b0, eq: 1'b1, mxIdx: 8'd0, mnIdx: 8'd0});
    applyStimulus(0, 8'd7, 0);
    applyStimulus(0, 8'd7, 0);
    applyStimulus(0, 8'd7, 1);
    expA.push_back('{mx: 8'hFF, mn: 8'h00, cnt: 8'd2, ovf: 1'b0, eq: 1'b0, mxIdx: 8'd0, mnIdx: 8'd1});
    applyStimulus(0, 8'hFF, 0);
    applyStimulus(0, 8'h00, 1);

    $display("[TB] stall in HOLD with pending sample");
    @(posedge clk); #1;
    busA.out_ready = 1'b0;
    expA.push_back('{mx: 8'd6, mn: 8'd2, cnt: 8'd2, ovf: 1'b0, eq: 1'b0, mxIdx: 8'd1, mnIdx: 8'd0});
    applyStimulus(0, 8'd2, 0);
    applyStimulus(0, 8'd6, 1);
    busA.in_valid = 1'b1; busA.in_data = 8'h11; busA.in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("stallValid",   32'(busA.out_valid), 32'd1);
      checkOutput("stallInReady", 32'(busA.in_ready),  32'd0);
      checkOutput("stallMax",     32'(busA.out_max),   32'd6);
      checkOutput("stallMin",     32'(busA.out_min),   32'd2);
      checkOutput("stallCount",   32'(busA.out_count), 32'd2);
    end
    expA.push_back('{mx: 8'h11, mn: 8'h11, cnt: 8'd1, ovf: 1'b0, eq: 1'b1, mxIdx: 8'd0, mnIdx: 8'd0});
    busA.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseInReady", 32'(busA.in_ready), 32'd1);
    @(posedge clk); #1;
    busA.in_valid = 1'b0;
    busA.in_last = 1'b0;

    $display("[TB] saturation on 3-bit counter");
    longFrame = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd12, 8'd3};
    expB.push_back('{mx: 8'd12, mn: 8'd1, cnt: 8'd7, ovf: 1'b1, eq: 1'b0, mxIdx: 8'd7, mnIdx: 8'd1});
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, longFrame[i], (i == 9));
    end

    $display("[TB] reset mid-frame");
    guard = 0;
    while ((expA.size() != 0 || expB.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) reportFail("drainBeforeReset");
    applyStimulus(0, 8'd8, 0);
    applyStimulus(0, 8'd20, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetState();
    rst = 1'b0;
    expA.push_back('{mx: 8'd4, mn: 8'd1, cnt: 8'd2, ovf: 1'b0, eq: 1'b0, mxIdx: 8'd0, mnIdx: 8'd1});
    applyStimulus(0, 8'd4, 0);
    applyStimulus(0, 8'd1, 1);

    guard = 0;
    while ((expA.size() != 0 || expB.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) reportFail("scoreboardDrain");
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
